ram_responder: RTL and testbench
================================

// Module: ram_responder
// PURPOSE
//  Word-organised RAM responder for the processor memory port. It answers
//  single-cycle readReq/writeReq pulses with single-cycle readAck/writeAck
//  pulses after a programmable latency, and holds read data on ramIn.
//  A side load port preloads program/data words before execution.
//  Flags protocol and alignment faults for the bench and debug logic.
// PARAMETERS
//  ADDR_WIDTH     8   word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words
//  READ_LATENCY   2   cycles from request sample edge to readAck edge (>=1)
//  WRITE_LATENCY  1   cycles from request sample edge to writeAck edge (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high
//  ramAddress   in   32  byte address from initiator; held stable until ack
//  ramOut       in   32  write data from initiator; held stable until writeAck
//  readReq      in   1   read request, one-cycle pulse
//  writeReq     in   1   write request, one-cycle pulse
//  ramIn        out  32  read data; valid with readAck, held until next read completes
//  readAck      out  1   one-cycle read completion pulse
//  writeAck     out  1   one-cycle write completion pulse
//  loadEn       in   1   preload strobe
//  loadAddr     in   ADDR_WIDTH  preload word address
//  loadData     in   32  preload data
//  busy         out  1   high while an access is in flight (state != IDLE)
//  protocolErr  out  1   sticky: illegal request or load seen
//  alignErr     out  1   sticky: access with ramAddress[1:0] != 0
// BEHAVIOUR
//  Reset: ramIn=0, readAck=0, writeAck=0, busy=0, protocolErr=0, alignErr=0,
//   state=IDLE, latency counter=0. Memory contents are not cleared.
//  Word index = ramAddress[ADDR_WIDTH+1:2]. Upper address bits are ignored
//   (aliasing). Low bits are ignored for the access; nonzero low bits set alignErr.
//  State machine:
//   IDLE: writeReq=1 -> latch index/data, cnt=WRITE_LATENCY-1, go WBUSY.
//         readReq=1 only -> latch index, cnt=READ_LATENCY-1, go RBUSY.
//         Both readReq and writeReq high -> write taken, read dropped,
//         protocolErr set.
//         loadEn with no request -> mem[loadAddr]=loadData, stay IDLE.
//   RBUSY: cnt==0 -> ramIn<=mem[index], readAck<=1 for one cycle, go IDLE.
//          Otherwise cnt--.
//   WBUSY: cnt==0 -> mem[index]<=data, writeAck<=1 for one cycle, go IDLE.
//          Otherwise cnt--.
//  Latency: request sampled at edge N; ack high after edge N+LAT. With LAT=1,
//   ack is visible in the cycle after the request pulse.
//  Memory write commits on the same edge that raises writeAck.
//  A read issued in the cycle after a writeAck returns the new data.
//  readReq, writeReq or loadEn while busy=1: ignored, protocolErr set, and the
//   in-flight access completes unaffected.
//  loadEn in the same cycle as a request in IDLE: load ignored, protocolErr set.
//  Acks never assert in consecutive cycles: the minimum request spacing is the
//   ack cycle plus one.
//  Reset mid-access: the access is abandoned, no ack is issued, and an
//   uncommitted write is not performed.
// TESTING
//  1. Preload mem[0..3]=11,22,33,44 via loadEn; read ramAddress=8 with READ_LATENCY=2
//     -> readAck 2 cycles after the pulse, ramIn=33, busy high for 2 cycles.
//  2. Write 0xDEADBEEF to ramAddress=0x10, then read 0x10
//     -> writeAck after 1 cycle, then ramIn=0xDEADBEEF. ramIn holds the value
//     until the next read.
//  3. readReq and writeReq in the same cycle at address 4 with data 5
//     -> writeAck only, mem[1]=5, protocolErr=1, no readAck.
//  4. readReq again while RBUSY -> first read acks normally with correct data,
//     no second ack, protocolErr=1.
//  5. Read ramAddress=0x402 with ADDR_WIDTH=8 -> aliases to word 0
//     (0x402 -> index 0), alignErr=1, readAck issued.
//  6. Assert reset during WBUSY with WRITE_LATENCY=3 -> no writeAck, mem unchanged,
//     all outputs at reset values; the next read returns the old data.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder: word RAM with programmable read/write ack latency, preload port and sticky fault flags
module ram_responder #(
  parameter int ADDR_WIDTH    = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           ramAddress,
  input  logic [31:0]           ramOut,
  input  logic                  readReq,
  input  logic                  writeReq,
  output logic [31:0]           ramIn,
  output logic                  readAck,
  output logic                  writeAck,
  input  logic                  loadEn,
  input  logic [ADDR_WIDTH-1:0] loadAddr,
  input  logic [31:0]           loadData,
  output logic                  busy,
  output logic                  protocolErr,
  output logic                  alignErr
);
  localparam int CW = 8;
  typedef enum logic [1:0] {IDLE, RBUSY, WBUSY} state_t;
  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] idx, wa;
  logic [31:0]           data, wd;
  logic                  we, rd_done, wr_done, req, perr;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^ramAddress[31:ADDR_WIDTH+2];
  assign busy = state != IDLE;
  assign req  = readReq | writeReq;
  assign perr = busy ? (req | loadEn) : ((readReq & writeReq) | (loadEn & req));
  // Next state, latency countdown and the single memory write port (preload or committed write)
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we      = 1'b0;
    wa      = loadAddr;
    wd      = loadData;
    rd_done = 1'b0;
    wr_done = 1'b0;
    case (state)
      IDLE: begin
        if (writeReq) begin
          state_n = WBUSY;
          cnt_n   = CW'(WRITE_LATENCY - 1);
        end else if (readReq) begin
          state_n = RBUSY;
          cnt_n   = CW'(READ_LATENCY - 1);
        end else we = loadEn;
      end
      RBUSY: begin
        if (cnt == '0) begin
          rd_done = 1'b1;
          state_n = IDLE;
        end else cnt_n = cnt - 1'b1;
      end
      WBUSY: begin
        if (cnt == '0) begin
          wr_done = 1'b1;
          we      = 1'b1;
          wa      = idx;
          wd      = data;
          state_n = IDLE;
        end else cnt_n = cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // Memory array is never cleared; writes are gated by the reset-controlled FSM
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  // FSM state, request latching, ack pulses, read data and sticky fault flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      data        <= '0;
      ramIn       <= '0;
      readAck     <= 1'b0;
      writeAck    <= 1'b0;
      protocolErr <= 1'b0;
      alignErr    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      readAck     <= rd_done;
      writeAck    <= wr_done;
      protocolErr <= protocolErr | perr;
      if (rd_done) ramIn <= mem[idx];
      if (!busy && req) begin
        idx      <= ramAddress[ADDR_WIDTH+1:2];
        data     <= ramOut;
        alignErr <= alignErr | (ramAddress[1:0] != 2'b00);
      end
    end
  end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed checks of latency, data, aliasing and fault flags
module tb_ram_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ram_address = '0;
  logic [31:0] ram_out = '0;
  logic        read_req = 1'b0;
  logic        write_req = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic [31:0] ram_in, ram_in3;
  logic        read_ack, write_ack, busy, protocol_err, align_err;
  logic        read_ack3, write_ack3, busy3, protocol_err3, align_err3;
  int          total = 0;
  int          fails = 0;

  ram_responder dut (
    .clk(clk), .reset(reset), .ramAddress(ram_address), .ramOut(ram_out),
    .readReq(read_req), .writeReq(write_req), .ramIn(ram_in), .readAck(read_ack),
    .writeAck(write_ack), .loadEn(load_en), .loadAddr(load_addr), .loadData(load_data),
    .busy(busy), .protocolErr(protocol_err), .alignErr(align_err)
  );

  ram_responder #(.WRITE_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .ramAddress(ram_address), .ramOut(ram_out),
    .readReq(read_req), .writeReq(write_req), .ramIn(ram_in3), .readAck(read_ack3),
    .writeAck(write_ack3), .loadEn(load_en), .loadAddr(load_addr), .loadData(load_data),
    .busy(busy3), .protocolErr(protocol_err3), .alignErr(align_err3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ramIn", ram_in, 0);
    chk("rst_readAck", 32'(read_ack), 0);
    chk("rst_writeAck", 32'(write_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_protocolErr", 32'(protocol_err), 0);
    chk("rst_alignErr", 32'(align_err), 0);
    // preload 11,22,33,44 then read byte address 8
    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1;
      load_addr = 8'(i);
      load_data = 32'(11 * (i + 1));
      tick();
    end
    load_en = 1'b0;
    ram_address = 32'd8;
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    chk("t1_busy_c1", 32'(busy), 1);
    chk("t1_ack_c1", 32'(read_ack), 0);
    tick();
    chk("t1_busy_c2", 32'(busy), 1);
    chk("t1_ack_c2", 32'(read_ack), 0);
    tick();
    chk("t1_ack_c3", 32'(read_ack), 1);
    chk("t1_data", ram_in, 33);
    chk("t1_busy_c3", 32'(busy), 0);
    tick();
    chk("t1_ack_pulse", 32'(read_ack), 0);
    chk("t1_hold", ram_in, 33);
    chk("t1_perr", 32'(protocol_err), 0);
    // write then read back 0x10
    ram_address = 32'h10;
    ram_out = 32'hDEADBEEF;
    write_req = 1'b1;
    tick();
    write_req = 1'b0;
    chk("t2_wack_c1", 32'(write_ack), 0);
    chk("t2_hold_old", ram_in, 33);
    tick();
    chk("t2_wack_c2", 32'(write_ack), 1);
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    chk("t2_wack_pulse", 32'(write_ack), 0);
    tick();
    tick();
    chk("t2_rack", 32'(read_ack), 1);
    chk("t2_data", ram_in, 32'hDEADBEEF);
    tick();
    tick();
    chk("t2_hold", ram_in, 32'hDEADBEEF);
    chk("t2_perr", 32'(protocol_err), 0);
    // simultaneous read+write at address 4
    ram_address = 32'd4;
    ram_out = 32'd5;
    read_req = 1'b1;
    write_req = 1'b1;
    tick();
    read_req = 1'b0;
    write_req = 1'b0;
    chk("t3_perr", 32'(protocol_err), 1);
    tick();
    chk("t3_wack", 32'(write_ack), 1);
    chk("t3_no_rack", 32'(read_ack), 0);
    tick();
    chk("t3_no_rack2", 32'(read_ack), 0);
    tick();
    chk("t3_no_rack3", 32'(read_ack), 0);
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    tick();
    tick();
    chk("t3_rack", 32'(read_ack), 1);
    chk("t3_mem1", ram_in, 5);
    // second read while busy is dropped
    do_reset();
    chk("t4_perr_clr", 32'(protocol_err), 0);
    chk("t4_ramIn_clr", ram_in, 0);
    ram_address = 32'd0;
    read_req = 1'b1;
    tick();
    ram_address = 32'd12;
    tick();
    read_req = 1'b0;
    chk("t4_perr", 32'(protocol_err), 1);
    chk("t4_busy", 32'(busy), 1);
    ram_address = 32'd0;
    tick();
    chk("t4_rack", 32'(read_ack), 1);
    chk("t4_data", ram_in, 11);
    tick();
    chk("t4_no_second", 32'(read_ack), 0);
    tick();
    chk("t4_no_second2", 32'(read_ack), 0);
    chk("t4_idle", 32'(busy), 0);
    // aliased, misaligned read
    do_reset();
    chk("t5_align_clr", 32'(align_err), 0);
    ram_address = 32'h402;
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    chk("t5_align", 32'(align_err), 1);
    tick();
    tick();
    chk("t5_rack", 32'(read_ack), 1);
    chk("t5_data", ram_in, 11);
    chk("t5_perr", 32'(protocol_err), 0);
    // reset mid-write on the 3-cycle write instance
    do_reset();
    ram_address = 32'hC;
    ram_out = 32'h99;
    write_req = 1'b1;
    tick();
    write_req = 1'b0;
    chk("t6_busy_c1", 32'(busy3), 1);
    tick();
    chk("t6_busy_c2", 32'(busy3), 1);
    chk("t6_wack_c2", 32'(write_ack3), 0);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy3), 0);
    chk("t6_rst_wack", 32'(write_ack3), 0);
    chk("t6_rst_ramIn", ram_in3, 0);
    chk("t6_rst_perr", 32'(protocol_err3), 0);
    tick();
    chk("t6_rst_wack2", 32'(write_ack3), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_no_wack", 32'(write_ack3), 0);
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    tick();
    chk("t6_no_wack2", 32'(write_ack3), 0);
    tick();
    chk("t6_rack", 32'(read_ack3), 1);
    chk("t6_old_data", ram_in3, 44);
    chk("t6_align", 32'(align_err3), 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
